// File: rtl/spi_ram_arbiter.sv
// Arbitrates one single-port RAM between an SPI side and a local user side.
// Optional stall statistics counter is built only when SPI_ARB_STAT_EN is defined.
//
// state   | meaning
// IDLE    | no owner; picks next owner, SPI wins a tie unless it owned last
// SPI_OWN | SPI side owns the RAM; spi_gnt follows spi_req
// USR_OWN | user side owns the RAM; usr_gnt follows usr_req
module spi_ram_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int RAM_LAT   = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              spi_req,
  input  logic              spi_wr,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_gnt,
  output logic              spi_rvalid,
  input  logic              usr_req,
  input  logic              usr_wr,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_gnt,
  output logic              usr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SPI_OWN = 2'd1, USR_OWN = 2'd2} state_t;

  state_t             state;
  logic               last_usr;
  logic [7:0]         burst_cnt;
  logic [RAM_LAT-1:0] tag_v;
  logic [RAM_LAT-1:0] tag_usr;
  logic               at_limit;

  assign spi_gnt   = (state == SPI_OWN) & spi_req;
  assign usr_gnt   = (state == USR_OWN) & usr_req;
  assign ram_en    = spi_gnt | usr_gnt;
  assign ram_we    = spi_gnt ? spi_wr : (usr_gnt & usr_wr);
  assign ram_addr  = spi_gnt ? spi_addr  : (usr_gnt ? usr_addr  : '0);
  assign ram_wdata = spi_gnt ? spi_wdata : (usr_gnt ? usr_wdata : '0);
  assign at_limit  = (burst_cnt == 8'(MAX_BURST - 1));

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_usr  <= 1'b1;
      burst_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= 8'd0;
          if (spi_req && (!usr_req || last_usr)) state <= SPI_OWN;
          else if (usr_req)                      state <= USR_OWN;
        end
        SPI_OWN: begin
          if (!spi_req) begin
            burst_cnt <= 8'd0;
            last_usr  <= 1'b0;
            state     <= usr_req ? USR_OWN : IDLE;
          end else if (at_limit) begin
            burst_cnt <= 8'd0;
            if (usr_req) begin
              last_usr <= 1'b0;
              state    <= USR_OWN;
            end
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        USR_OWN: begin
          if (!usr_req) begin
            burst_cnt <= 8'd0;
            last_usr  <= 1'b1;
            state     <= spi_req ? SPI_OWN : IDLE;
          end else if (at_limit) begin
            burst_cnt <= 8'd0;
            if (spi_req) begin
              last_usr <= 1'b1;
              state    <= SPI_OWN;
            end
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Each read carries its owner tag down the pipe so late returns survive ownership changes.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      tag_v   <= '0;
      tag_usr <= '0;
    end else begin
      tag_v[0]   <= ram_en & ~ram_we;
      tag_usr[0] <= usr_gnt;
      for (int i = 1; i < RAM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_usr[i] <= tag_usr[i-1];
      end
    end
  end

  assign spi_rvalid = tag_v[RAM_LAT-1] & ~tag_usr[RAM_LAT-1];
  assign usr_rvalid = tag_v[RAM_LAT-1] &  tag_usr[RAM_LAT-1];
  assign rdata      = (spi_rvalid | usr_rvalid) ? ram_rdata : '0;

`ifdef SPI_ARB_STAT_EN
  logic stall;
  assign stall = (spi_req & ~spi_gnt) | (usr_req & ~usr_gnt);

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n)                                 conflict_cnt <= 16'h0000;
    else if (stall && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'h0001;
  end
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: one instance with RAM_LAT=1 and one with RAM_LAT=3,
// fed identical stimulus, each backed by a write-first RAM model.
module tb_spi_ram_arbiter;

`ifdef SPI_ARB_STAT_EN
  localparam int STAT_ON = 1;
`else
  localparam int STAT_ON = 0;
`endif

  logic        clk_25m = 1'b0;
  logic        rst_n;
  logic        spi_req, spi_wr, usr_req, usr_wr;
  logic [11:0] spi_addr, usr_addr;
  logic [7:0]  spi_wdata, usr_wdata;

  logic        spi_gnt1, spi_rvalid1, usr_gnt1, usr_rvalid1, ram_en1, ram_we1;
  logic [7:0]  rdata1, ram_wdata1, ram_rdata1;
  logic [11:0] ram_addr1;
  logic [15:0] conflict_cnt1;

  logic        spi_gnt3, spi_rvalid3, usr_gnt3, usr_rvalid3, ram_en3, ram_we3;
  logic [7:0]  rdata3, ram_wdata3, ram_rdata3;
  logic [11:0] ram_addr3;
  logic [15:0] conflict_cnt3;

  int checks = 0;
  int errors = 0;
  int ugnt   = 0;

  always #20 clk_25m = ~clk_25m;

  spi_ram_arbiter #(.ADDR_W(12), .DATA_W(8), .RAM_LAT(1), .MAX_BURST(16)) dut1 (
    .clk_25m(clk_25m), .rst_n(rst_n),
    .spi_req(spi_req), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_gnt(spi_gnt1), .spi_rvalid(spi_rvalid1),
    .usr_req(usr_req), .usr_wr(usr_wr), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_gnt(usr_gnt1), .usr_rvalid(usr_rvalid1),
    .rdata(rdata1), .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .conflict_cnt(conflict_cnt1)
  );

  spi_ram_arbiter #(.ADDR_W(12), .DATA_W(8), .RAM_LAT(3), .MAX_BURST(16)) dut3 (
    .clk_25m(clk_25m), .rst_n(rst_n),
    .spi_req(spi_req), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_gnt(spi_gnt3), .spi_rvalid(spi_rvalid3),
    .usr_req(usr_req), .usr_wr(usr_wr), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_gnt(usr_gnt3), .usr_rvalid(usr_rvalid3),
    .rdata(rdata3), .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .conflict_cnt(conflict_cnt3)
  );

  logic [7:0] mem1 [0:4095];
  logic [7:0] mem3 [0:4095];
  logic [7:0] p3   [0:2];

  always @(posedge clk_25m) begin
    if (ram_en1) begin
      if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
      ram_rdata1 <= ram_we1 ? ram_wdata1 : mem1[ram_addr1];
    end
  end

  always @(posedge clk_25m) begin
    if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_wdata3;
    p3[0] <= ram_en3 ? (ram_we3 ? ram_wdata3 : mem3[ram_addr3]) : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram_rdata3 = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl1"}, 32'({spi_gnt1, usr_gnt1, spi_rvalid1, usr_rvalid1, ram_en1, ram_we1}), 32'd0);
    chk({tag, "_bus1"}, 32'({ram_addr1, ram_wdata1, rdata1, conflict_cnt1}), 32'd0);
    chk({tag, "_ctl3"}, 32'({spi_gnt3, usr_gnt3, spi_rvalid3, usr_rvalid3, ram_en3, ram_we3}), 32'd0);
    chk({tag, "_bus3"}, 32'({ram_addr3, ram_wdata3, rdata3, conflict_cnt3}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    spi_req = 1'b1; spi_wr = 1'b1; spi_addr = 12'h010; spi_wdata = 8'hA5;
    usr_req = 1'b1; usr_wr = 1'b0; usr_addr = 12'h020; usr_wdata = 8'h3C;
    next(); next(); #1;
    chk_quiet("reset");

    // cycle 0: release with both requests already high
    rst_n = 1'b1; #1;
    chk("c0_gnt_idle", 32'({spi_gnt1, usr_gnt1}), 32'd0);

    next();  // cycle 1: SPI wins the first tie, writes A5 to 0x010
    chk("c1_gnt", 32'({spi_gnt1, usr_gnt1}), 32'b10);
    chk("c1_ram_ctl", 32'({ram_en1, ram_we1}), 32'b11);
    chk("c1_ram_addr", 32'(ram_addr1), 32'h010);
    chk("c1_ram_wdata", 32'(ram_wdata1), 32'hA5);

    next(); spi_wr = 1'b0; #1;  // cycle 2: SPI reads 0x010
    chk("c2_read_ctl", 32'({spi_gnt1, ram_en1, ram_we1}), 32'b110);

    next(); spi_req = 1'b0; #1;  // cycle 3
    chk("c3_spi_rvalid1", 32'({spi_rvalid1, usr_rvalid1}), 32'b10);
    chk("c3_rdata1", 32'(rdata1), 32'hA5);
    chk("c3_no_gnt", 32'({spi_gnt1, usr_gnt1, ram_en1}), 32'd0);

    // cycles 4..19: user owns; writes 3C to 0x020 then a final read in its last burst slot
    next(); spi_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) next();
      usr_wr = (i < 15);
      #1;
      if (usr_gnt1 && !spi_gnt1) ugnt++;
      if (i == 1) begin
        chk("c5_spi_rvalid3", 32'({spi_rvalid3, usr_rvalid3}), 32'b10);
        chk("c5_rdata3", 32'(rdata3), 32'hA5);
      end
    end
    chk("usr_burst_len", 32'(ugnt), 32'd16);

    next(); usr_req = 1'b0; #1;  // cycle 20: SPI takes over, reads 0x010
    chk("c20_gnt", 32'({spi_gnt1, usr_gnt1}), 32'b10);
    chk("c20_usr_rvalid1", 32'({spi_rvalid1, usr_rvalid1}), 32'b01);
    chk("c20_rdata1", 32'(rdata1), 32'h3C);

    next(); spi_wr = 1'b1; spi_addr = 12'h030; spi_wdata = 8'h5A; #1;  // cycle 21
    chk("c21_spi_rvalid1", 32'({spi_rvalid1, usr_rvalid1}), 32'b10);
    chk("c21_rdata1", 32'(rdata1), 32'hA5);
    chk("c21_usr_rvalid3", 32'({spi_rvalid3, usr_rvalid3}), 32'b00);

    next(); #1;  // cycle 22: late user read returns while SPI owns
    chk("c22_usr_rvalid3", 32'({spi_rvalid3, usr_rvalid3}), 32'b01);
    chk("c22_rdata3", 32'(rdata3), 32'h3C);

    next(); usr_req = 1'b1; #1;  // cycle 23
    chk("c23_spi_rvalid3", 32'({spi_rvalid3, usr_rvalid3}), 32'b10);
    chk("c23_rdata3", 32'(rdata3), 32'hA5);
    chk("c23_usr_stalled", 32'({spi_gnt1, usr_gnt1}), 32'b10);

    next(); next(); next(); next();  // user held through cycle 27
    next(); usr_req = 1'b0; #1;      // cycle 28
    chk("c28_conflict_cnt", 32'(conflict_cnt1), 32'(STAT_ON * 25));
    chk("c28_spi_owns", 32'({spi_gnt1, usr_gnt1}), 32'b10);

    next(); spi_wr = 1'b0; #1;  // cycle 29: read grant of 0x030
    chk("c29_read_grant", 32'({spi_gnt1, ram_en1, ram_we1}), 32'b110);

    next(); rst_n = 1'b0; #1;  // cycle 30: reset while reads are in flight
    chk_quiet("midrst");

    next(); rst_n = 1'b1; spi_wr = 1'b1; #1;  // cycle 31
    chk("c31_idle", 32'({spi_gnt1, spi_gnt3}), 32'd0);
    chk("c31_no_rvalid", 32'({spi_rvalid1, usr_rvalid1, spi_rvalid3, usr_rvalid3}), 32'd0);

    next(); #1;  // cycle 32: where the discarded RAM_LAT=3 read would have landed
    chk("c32_no_rvalid3", 32'({spi_rvalid3, usr_rvalid3}), 32'd0);
    chk("c32_gnt", 32'({spi_gnt1, spi_gnt3}), 32'b11);

    next(); #1;  // cycle 33
    chk("c33_conflict_cnt", 32'(conflict_cnt1), 32'(STAT_ON));
    chk("c33_conflict_cnt3", 32'(conflict_cnt3), 32'(STAT_ON));

    spi_req = 1'b0;
    next();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
